// File: rtl/neu_gen_if.sv
// Control, neighbour-cost and result bundle for one neu_gen planner cell.
// The slave side is the cell; the master side is whatever tiles or drives it.
interface neu_gen_if #(
   parameter int COST_W   = 12,
   parameter int WEIGHT_W = 4
);
   logic                  en;
   logic                  clr;
   logic                  inval;
   logic                  ld;
   logic [WEIGHT_W-1:0]   ld_weight;
   logic [8*COST_W-1:0]   nbr_cost;
   logic [COST_W-1:0]     path_cost;
   logic [2:0]            path_dir;
   logic                  path_mod;
   logic                  stable;

   modport slave (
      input  en, clr, inval, ld, ld_weight, nbr_cost,
      output path_cost, path_dir, path_mod, stable
   );

   modport master (
      output en, clr, inval, ld, ld_weight, nbr_cost,
      input  path_cost, path_dir, path_mod, stable
   );
endinterface

// File: rtl/neu_gen.sv
// Wavefront planner cell: two-stage min(neighbour + step) relaxation with
// saturating INF arithmetic, change pulse and local convergence counter.
module neu_gen #(
   parameter int COST_W    = 12,
   parameter int WEIGHT_W  = 4,
   parameter int CONNECT   = 8,
   parameter int MONOTONIC = 1,
   parameter int STABLE_N  = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   neu_gen_if.slave  bus
);
   localparam int                SW    = COST_W + WEIGHT_W + 2;
   localparam logic [COST_W-1:0] INF   = {COST_W{1'b1}};
   localparam logic [WEIGHT_W-1:0] WOBST = {WEIGHT_W{1'b1}};
   localparam logic [3:0]        STAB  = 4'(STABLE_N);

   logic [WEIGHT_W-1:0]          weight_q;
   logic [SW-1:0]                step_card;
   logic [SW-1:0]                step_diag;
   logic [7:0][COST_W-1:0]       sum_d;
   logic [7:0][COST_W-1:0]       sum_q;
   logic                         s1_valid_q;
   logic                         obst_q;
   logic [COST_W-1:0]            cand;
   logic [2:0]                   cand_dir;
   logic [COST_W-1:0]            cost_d, cost_q;
   logic [2:0]                   dir_d, dir_q;
   logic                         mod_q;
   logic [3:0]                   cnt_d, cnt_q;
   logic                         changed;
   logic                         upd_en;

   // Half-unit steps: cardinal = 2w, diagonal = 3w (1.5x).
   assign step_card = SW'(weight_q) << 1;
   assign step_diag = (SW'(weight_q) << 1) + SW'(weight_q);

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_sum
         logic [COST_W-1:0] nbr;
         logic [SW-1:0]     raw;
         assign nbr = bus.nbr_cost[gi*COST_W +: COST_W];
         assign raw = SW'(nbr) + (((gi % 2) == 1) ? step_diag : step_card);
         if (((gi % 2) == 1) && (CONNECT == 4)) begin : g_off
            assign sum_d[gi] = INF;
         end else begin : g_on
            assign sum_d[gi] = ((nbr == INF) || (raw >= SW'(INF))) ? INF : raw[COST_W-1:0];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q      <= '1;
         s1_valid_q <= 1'b0;
         obst_q     <= 1'b0;
      end else if (bus.en) begin
         sum_q      <= sum_d;
         s1_valid_q <= 1'b1;
         obst_q     <= (weight_q == WOBST);
      end
   end

   // Strict less-than keeps the lowest direction on ties.
   always_comb begin
      cand     = sum_q[0];
      cand_dir = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (sum_q[k] < cand) begin
            cand     = sum_q[k];
            cand_dir = 3'(k);
         end
      end
      if (obst_q) begin
         cand     = INF;
         cand_dir = 3'd0;
      end
   end

   assign upd_en = bus.en && s1_valid_q;

   always_comb begin
      cost_d = cost_q;
      dir_d  = dir_q;
      if (bus.clr) begin
         cost_d = '0;
      end else if (bus.inval) begin
         cost_d = INF;
         dir_d  = 3'd0;
      end else if (upd_en) begin
         if ((MONOTONIC != 0) ? (cand < cost_q) : (cand != cost_q)) begin
            cost_d = cand;
            dir_d  = cand_dir;
         end
      end
   end

   assign changed = (cost_d != cost_q);

   always_comb begin
      cnt_d = cnt_q;
      if (changed || bus.clr || bus.inval || bus.ld) begin
         cnt_d = '0;
      end else if (upd_en && (cnt_q != STAB)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_q <= '0;
         cost_q   <= INF;
         dir_q    <= 3'd0;
         mod_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (bus.ld) begin
            weight_q <= bus.ld_weight;
         end
         cost_q <= cost_d;
         dir_q  <= dir_d;
         mod_q  <= changed;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.path_cost = cost_q;
   assign bus.path_dir  = dir_q;
   assign bus.path_mod  = mod_q;
   assign bus.stable    = (cnt_q == STAB);
endmodule

// File: tb/tb_neu_gen.sv
// Directed bench for neu_gen: expected cost/dir pairs are queued at stimulus
// time and popped by per-instance monitors on every path_mod pulse.
module tb_neu_gen;
   localparam logic [11:0] INF = 12'hFFF;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   neu_gen_if #(.COST_W(12), .WEIGHT_W(4)) ifa ();
   neu_gen_if #(.COST_W(12), .WEIGHT_W(4)) ifb ();
   neu_gen_if #(.COST_W(12), .WEIGHT_W(4)) ifc ();

   neu_gen #(.COST_W(12), .WEIGHT_W(4), .CONNECT(8), .MONOTONIC(1), .STABLE_N(4))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   neu_gen #(.COST_W(12), .WEIGHT_W(4), .CONNECT(4), .MONOTONIC(1), .STABLE_N(4))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   neu_gen #(.COST_W(12), .WEIGHT_W(4), .CONNECT(8), .MONOTONIC(0), .STABLE_N(4))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   int checks   = 0;
   int failures = 0;
   logic [14:0] qa[$];
   logic [14:0] qb[$];
   logic [14:0] qc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [95:0] nb(input logic [11:0] n, ne, e, se, s, sw, w, nw);
      return {nw, w, sw, s, se, e, ne, n};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitors: every path_mod pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      logic [14:0] e;
      if (rst_n && ifa.path_mod) begin
         if (qa.size() == 0) chk("a_unexpected_mod", 32'(ifa.path_mod), 0);
         else begin
            e = qa.pop_front();
            chk("a_mod_cost", 32'(ifa.path_cost), 32'(e[14:3]));
            chk("a_mod_dir", 32'(ifa.path_dir), 32'(e[2:0]));
            $display("a: path_mod cost=%0d dir=%0d", ifa.path_cost, ifa.path_dir);
         end
      end
   end

   always @(negedge clk) begin
      logic [14:0] e;
      if (rst_n && ifb.path_mod) begin
         if (qb.size() == 0) chk("b_unexpected_mod", 32'(ifb.path_mod), 0);
         else begin
            e = qb.pop_front();
            chk("b_mod_cost", 32'(ifb.path_cost), 32'(e[14:3]));
            chk("b_mod_dir", 32'(ifb.path_dir), 32'(e[2:0]));
            $display("b: path_mod cost=%0d dir=%0d", ifb.path_cost, ifb.path_dir);
         end
      end
   end

   always @(negedge clk) begin
      logic [14:0] e;
      if (rst_n && ifc.path_mod) begin
         if (qc.size() == 0) chk("c_unexpected_mod", 32'(ifc.path_mod), 0);
         else begin
            e = qc.pop_front();
            chk("c_mod_cost", 32'(ifc.path_cost), 32'(e[14:3]));
            chk("c_mod_dir", 32'(ifc.path_dir), 32'(e[2:0]));
            $display("c: path_mod cost=%0d dir=%0d", ifc.path_cost, ifc.path_dir);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      {ifa.en, ifa.clr, ifa.inval, ifa.ld} = '0;
      {ifb.en, ifb.clr, ifb.inval, ifb.ld} = '0;
      {ifc.en, ifc.clr, ifc.inval, ifc.ld} = '0;
      ifa.ld_weight = '0; ifb.ld_weight = '0; ifc.ld_weight = '0;
      ifa.nbr_cost = '1; ifb.nbr_cost = '1; ifc.nbr_cost = '1;
      tick(2);
      rst_n = 1'b1;
      chk("rst_a_cost", 32'(ifa.path_cost), 32'(INF));
      chk("rst_a_dir", 32'(ifa.path_dir), 0);
      chk("rst_a_mod", 32'(ifa.path_mod), 0);
      chk("rst_a_stable", 32'(ifa.stable), 0);
      chk("rst_b_cost", 32'(ifb.path_cost), 32'(INF));
      chk("rst_c_cost", 32'(ifc.path_cost), 32'(INF));

      // All neighbours INF, weight 5: cost stays INF and settles to stable.
      ifa.ld = 1; ifa.ld_weight = 4'd5; ifa.en = 1;
      ifb.ld = 1; ifb.ld_weight = 4'd5; ifb.en = 1;
      ifc.ld = 1; ifc.ld_weight = 4'd5; ifc.en = 1;
      tick(1);
      ifa.ld = 0; ifb.ld = 0; ifc.ld = 0;
      tick(8);
      chk("t1_a_cost_inf", 32'(ifa.path_cost), 32'(INF));
      chk("t1_a_stable", 32'(ifa.stable), 1);

      // N=40 -> 40+10=50 dir 0; then NE=34 -> 34+15=49 dir 1.
      qa.push_back({12'd50, 3'd0});
      ifa.nbr_cost = nb(12'd40, INF, INF, INF, INF, INF, INF, INF);
      tick(4);
      chk("t2_a_cost_n", 32'(ifa.path_cost), 50);
      chk("t2_a_dir_n", 32'(ifa.path_dir), 0);
      qa.push_back({12'd49, 3'd1});
      ifa.nbr_cost = nb(12'd40, 12'd34, INF, INF, INF, INF, INF, INF);
      tick(4);
      chk("t2_a_cost_ne", 32'(ifa.path_cost), 49);
      chk("t2_a_dir_ne", 32'(ifa.path_dir), 1);

      // Monotonic: candidate rises to 70, cost must hold at 49.
      ifa.nbr_cost = nb(12'd60, INF, INF, INF, INF, INF, INF, INF);
      tick(4);
      chk("t5_a_mono_cost", 32'(ifa.path_cost), 49);
      chk("t5_a_mono_dir", 32'(ifa.path_dir), 1);

      // Saturation: FFE + 10 must clamp to INF with no change pulse.
      qa.push_back({INF, 3'd0});
      ifa.inval = 1;
      ifa.nbr_cost = nb(12'hFFE, INF, INF, INF, INF, INF, INF, INF);
      tick(1);
      ifa.inval = 0;
      tick(4);
      chk("t4_a_sat_cost", 32'(ifa.path_cost), 32'(INF));
      ifa.ld = 1; ifa.ld_weight = 4'd15;
      tick(1);
      ifa.ld = 0;
      ifa.nbr_cost = nb(12'd0, INF, INF, INF, INF, INF, INF, INF);
      tick(4);
      chk("t4_a_obst_cost", 32'(ifa.path_cost), 32'(INF));

      // clr beats inval with en low; then inval alone.
      ifa.en = 0;
      qa.push_back({12'd0, 3'd0});
      qa.push_back({INF, 3'd0});
      ifa.clr = 1; ifa.inval = 1;
      tick(1);
      chk("t6_a_clr_cost", 32'(ifa.path_cost), 0);
      ifa.clr = 0;
      tick(1);
      ifa.inval = 0;
      chk("t6_a_inval_cost", 32'(ifa.path_cost), 32'(INF));
      ifa.en = 1;
      tick(8);
      chk("t6_a_stable_pre_ld", 32'(ifa.stable), 1);
      ifa.en = 0; ifa.ld = 1; ifa.ld_weight = 4'd3;
      tick(1);
      ifa.ld = 0;
      chk("t6_a_stable_cleared", 32'(ifa.stable), 0);
      tick(3);
      chk("t6_a_frozen_cost", 32'(ifa.path_cost), 32'(INF));
      qa.push_back({12'd6, 3'd0});
      ifa.en = 1;
      tick(4);
      chk("t6_a_new_weight_cost", 32'(ifa.path_cost), 6);

      // CONNECT=4: NE=0 ignored, E=60 -> 70 dir 2.
      qb.push_back({12'd70, 3'd2});
      ifb.nbr_cost = nb(INF, 12'd0, 12'd60, INF, INF, INF, INF, INF);
      tick(4);
      chk("t3_b_cost", 32'(ifb.path_cost), 70);
      chk("t3_b_dir", 32'(ifb.path_dir), 2);

      // MONOTONIC=0: N 40 -> 50, then N 60 -> cost rises to 70.
      qc.push_back({12'd50, 3'd0});
      ifc.nbr_cost = nb(12'd40, INF, INF, INF, INF, INF, INF, INF);
      tick(4);
      chk("t5_c_cost_50", 32'(ifc.path_cost), 50);
      qc.push_back({12'd70, 3'd0});
      ifc.nbr_cost = nb(12'd60, INF, INF, INF, INF, INF, INF, INF);
      tick(4);
      chk("t5_c_cost_70", 32'(ifc.path_cost), 70);
      chk("t5_c_dir", 32'(ifc.path_dir), 0);

      // Asynchronous reset mid-operation, checked between clock edges.
      rst_n = 1'b0;
      #2;
      chk("arst_a_cost", 32'(ifa.path_cost), 32'(INF));
      chk("arst_c_cost", 32'(ifc.path_cost), 32'(INF));
      chk("arst_b_dir", 32'(ifb.path_dir), 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      chk("qa_drained", 32'(qa.size()), 0);
      chk("qb_drained", 32'(qb.size()), 0);
      chk("qc_drained", 32'(qc.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/neu_gen.md
Name: neu_gen

Overview:
- Parametrised next-generation grid-cell relaxation element for the wavefront path planner.
- Each cycle it computes min(neighbour cost + step cost) over 4 or 8 neighbours through a 2-stage pipeline and updates its own cost register.
- Reports change, best direction and a local convergence flag.
- Instances tile the planner array; each cell's path_cost feeds its neighbours' *_cost inputs.

Parameters:
- COST_W, 12: cost width; fixed point, LSB = 0.5 unit; all-ones = INF (unreachable).
- WEIGHT_W, 4: cell weight width; all-ones weight = obstacle.
- CONNECT, 8: 8 = all neighbours; 4 = cardinal only (N, E, S, W).
- MONOTONIC, 1: 1 = cost only ever decreases; 0 = cost tracks the current minimum (may rise).
- STABLE_N, 4: consecutive unchanged update cycles before stable asserts (max 15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pipeline advance / update enable
- clr  in  1  force cost to 0 (goal cell)
- inval  in  1  force cost to INF (replan)
- ld  in  1  load weight
- ld_weight  in  WEIGHT_W  weight value
- nbr_cost  in  8*COST_W  neighbour costs; slice k = direction k (0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW)
- path_cost  out  COST_W  current cost
- path_dir  out  3  direction of the neighbour that produced the cost
- path_mod  out  1  one-cycle pulse when path_cost changed this cycle
- stable  out  1  path_cost unchanged for STABLE_N update cycles

Behaviour:
- Reset (async, rst_n low): path_cost = INF, weight = 0, path_dir = 0, path_mod = 0, stable = 0, stable counter = 0, pipeline valid = 0.
- Step costs, in half-units:
  - Cardinal = 2*weight.
  - Diagonal = 3*weight, i.e. 1.5x weight.
  - Widths are extended internally.
- Stage 1 (registered, when en):
  - sum[k] = nbr_cost[k] + step[k].
  - sum[k] = INF if nbr_cost[k] == INF, or if the sum is >= INF (saturate).
  - Diagonal slices are forced to INF when CONNECT = 4.
  - Stage-1 valid is set on the first en.
- Stage 2 (registered, when en and stage-1 valid):
  - Candidate = min over sum[k]; ties go to the lowest k.
  - Obstacle (weight all-ones): candidate = INF, dir = 0.
  - MONOTONIC = 1: update cost/dir only if candidate < path_cost.
  - MONOTONIC = 0: update whenever candidate != path_cost.
- Latency: a neighbour change visible at a clk edge appears on path_cost 2 en-cycles later.
- Priority, same cycle: clr > inval > stage-2 update.
  - clr: cost = 0, dir held.
  - inval: cost = INF, dir = 0.
  - Both act regardless of en.
- ld: weight <= ld_weight at the edge. It is independent of clr/inval. The new weight enters stage 1 on the same edge's next computation, so the cost reflects it 2 cycles later.
- path_mod: registered; 1 for the cycle after any edge where path_cost changed, from any source. Otherwise 0.
- Stable counter:
  - Cleared on any cost change, clr, inval or ld.
  - Increments on each en cycle with no change, saturating at STABLE_N.
  - stable = (counter == STABLE_N).
- en low: pipeline and cost frozen (except clr/inval/ld); counter holds.
- rst_n asserted mid-operation clears everything immediately. Pipeline valid restarts, so the first update occurs 2 en-cycles after release.

Test Plan:
1. Reset, weight=5 (ld), all neighbours INF, en=1 -> path_cost=0xFFF, path_mod=0; stable=1 after 4 update cycles.
2. N=20.0 (40) -> 2 cycles later path_cost=25.0 (50), dir=0, path_mod pulse; then NE=17.0 (34) -> 24.5 (49), dir=1.
3. CONNECT=4 instance, NE=0, E=30.0 (60), weight=5 -> path_cost=35.0 (70), dir=2 (diagonal ignored).
4. Saturation: N=0xFFE, others INF, weight=5 -> path_cost stays 0xFFF, no path_mod; obstacle weight=15 with N=0 -> 0xFFF.
5. MONOTONIC=1: cost 25.0 from N, raise N to 30.0 -> cost stays 25.0. MONOTONIC=0: same stimulus -> 35.0, path_mod pulse.
6. clr and inval in the same cycle -> cost=0; next cycle inval alone -> 0xFFF; ld during en=0 -> weight updates, cost frozen, stable cleared.
